mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Load/store initiator between the MEM pipeline stage and the data RAM port. Accepts one load or store per request and generates the RAM chip-enable, write-enable, word address, byte selects and write data. Realigns and sign/zero-extends load data. Splits any access crossing a 32-bit word boundary into two consecutive aligned RAM accesses, and holds the pipeline with a stall request until the access completes.

## Interface
- `AW`, 32: byte address width.
- `DW`, 32: data width; fixed at 32, since 4 byte selects are assumed.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous active-low reset.
- `req_valid` in 1: MEM stage has a memory op this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I width/sign code. Loads: LB=0, LH=1, LW=2, LBU=4, LHU=5. Stores: SB=0, SH=1, SW=2.
- `req_addr` in AW: byte address.
- `req_wdata` in DW: store data, right-aligned.
- `resp_valid` out 1: access complete; held for one cycle.
- `resp_rdata` out DW: extended load data; 0 for stores.
- `resp_err` out 1: illegal funct3; no RAM access is performed.
- `stall_req` out 1: pipeline must hold.
- `ram_ce` out 1: RAM chip enable, active high.
- `ram_we` out 1: RAM write enable, active high.
- `ram_addr` out AW: word-aligned byte address; bits [1:0] are always 0.
- `ram_sel` out 4: byte lane enables; bit n selects bits [8n+7:8n].
- `ram_wdata` out DW: lane-positioned write data.
- `ram_rdata` in DW: RAM read data, combinational from the `ram_*` outputs.

## Operation
- States:
  - IDLE: no access in progress.
  - ACC0: access to the lower word.
  - ACC1: access to the upper word.
  - DONE: response cycle.
- Reset behaviour: state returns to IDLE; every output is 0, including `ram_ce`, `ram_we`, `ram_sel`, `resp_valid` and `stall_req`.
- Request accept (IDLE with `req_valid`=1) registers:
  - off = `req_addr[1:0]`
  - base = word address
  - we, funct3
  - size mask: byte=0001, half=0011, word=1111
- Mask and data alignment:
  - 8-bit mask m = size mask << off.
  - 64-bit data w = `req_wdata` << (8·off).
  - Both are computed after truncating `req_wdata` to the access size.
- Illegal funct3 (load 3, 6 or 7; store ≥3) goes IDLE→DONE with `resp_err`=1. No RAM cycle is issued.
- ACC0 drives these registered outputs:
  - `ram_ce`=1, `ram_we`=we
  - `ram_addr`=base, `ram_sel`=m[3:0], `ram_wdata`=w[31:0]
  - Load: the lower 32 bits of the assembly register are captured from `ram_rdata` at the end of the cycle.
- ACC0 exit: goes to ACC1 if m[7:4]≠0, else to DONE.
- ACC1 drives:
  - `ram_addr`=base+4, wrapping modulo 2^AW.
  - `ram_sel`=m[7:4], `ram_wdata`=w[63:32].
  - Load: the upper 32 bits are captured.
- DONE: `ram_ce`=0 and `resp_valid`=1.
  - Load: `resp_rdata` = ({hi,lo} >> 8·off), truncated to the access size, then sign-extended for LB/LH or zero-extended for LBU/LHU/LW.
  - Store: `resp_rdata`=0.
  - DONE always returns to IDLE.
- Stores never read-modify-write; byte selects alone protect the unwritten lanes.
- In every state, `ram_ce`=0 implies `ram_we`=0 and `ram_sel`=0.

## Timing
- `stall_req` = (IDLE & `req_valid`) | ACC0 | ACC1. It is combinational on `req_valid` in IDLE and low in DONE.
- Aligned access: request accepted at cycle T; RAM access at T+1; `resp_valid` at T+2. Latency is 2 cycles.
- Word-crossing access: RAM accesses at T+1 and T+2; `resp_valid` at T+3.
- The pipeline advances in the DONE cycle. A new request may be accepted in the cycle after DONE; there is no back-to-back accept in DONE.
- Request inputs are ignored outside IDLE. A change on them mid-access has no effect.
- Reset asserted in ACC0/ACC1: at the next edge the state returns to IDLE and all outputs go to 0.
  - A store write already clocked at an earlier edge stands.
  - A second half not yet issued is dropped.
  - No response is produced.
- The RAM write commits at the rising edge that ends ACC0/ACC1.

## Structure
- Shared package/defines file holds:
  - funct3 codes (LB..LHU, SB..SW)
  - state encodings (IDLE=0, ACC0=1, ACC1=2, DONE=3)
  - size masks
  - the active-high enable constants used by the data RAM
- One combinational sub-module, `lsu_align`:
  - Store path: mask and data shifting.
  - Load path: extraction and extension.
- The FSM and registers stay in `mem_access_ctrl`.

## Test plan
- SW 0xDEADBEEF @0x100, then LW @0x100:
  - store: single access with `ram_sel`=1111 and `ram_addr`=0x100.
  - load: `resp_rdata`=0xDEADBEEF at T+2; `stall_req` high at T and T+1.
- SB 0x80 @0x103, then LB and LBU @0x103:
  - store: `ram_sel`=1000, `ram_wdata`[31:24]=0x80.
  - loads: 0xFFFFFF80 and 0x00000080; the other bytes of word 0x100 are unchanged.
- SW 0x11223344 @0x202 (crossing):
  - ACC0: addr 0x200, sel 1100, wdata 0x33440000.
  - ACC1: addr 0x204, sel 0011, wdata 0x00001122.
  - LW @0x202 then returns 0x11223344 at T+3.
- LH @0x207 after memory bytes 0x207=0x34 and 0x208=0x92:
  - two accesses; `resp_rdata`=0xFFFF9234.
  - LHU of the same address gives 0x00009234.
- Load with funct3=3: no `ram_ce` pulse; at T+1 `resp_err`=1, `resp_valid`=1, `resp_rdata`=0.
- Reset low during ACC0 of a crossing SW:
  - only the lower word is written.
  - next cycle: all outputs 0, state IDLE, no `resp_valid`.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_pkg
// Shared definitions for the load/store initiator:
//   - RV32I funct3 width/sign codes for loads and stores
//   - FSM state encoding
//   - byte-lane size masks
//   - active-high enable levels used by the data RAM
//   - helpers to classify funct3 and pick the size mask
// ---------------------------------------------------------------------------
package mem_access_ctrl_pkg;

    // Load codes
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    // Store codes
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    // Byte-lane masks before shifting by the address offset
    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    // Data RAM control levels (both strobes are active high)
    localparam logic RAM_EN  = 1'b1;
    localparam logic RAM_DIS = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Stores only know SB/SH/SW; loads additionally have LBU/LHU.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 > F3_SW);
        else
            return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    endfunction

    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return MASK_BYTE;
            2'd1:    return MASK_HALF;
            default: return MASK_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational data alignment for the load/store initiator.
// Store path: truncates store data to the access size and positions both the
//   byte-lane mask and the data across a 64-bit (two word) window.
// Load path: extracts the addressed bytes from a 64-bit assembled window and
//   sign- or zero-extends them to 32 bits.
// Ports:
//   st_funct3, st_off, st_wdata -> st_mask[7:0], st_data[63:0]
//   ld_funct3, ld_off, ld_data  -> ld_result[31:0]
// ---------------------------------------------------------------------------
module lsu_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [7:0]  st_mask,
    output logic [63:0] st_data,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [63:0] ld_data,
    output logic [31:0] ld_result
);

    logic [31:0] st_trunc;
    logic [31:0] ld_window;

    // Store data is cut to the access size before shifting so that stray
    // upper bits never land in a lane the mask does not enable.
    always_comb begin
        st_trunc = st_wdata;
        case (st_funct3[1:0])
            2'd0:    st_trunc = {24'b0, st_wdata[7:0]};
            2'd1:    st_trunc = {16'b0, st_wdata[15:0]};
            default: st_trunc = st_wdata;
        endcase
        st_mask = {4'b0000, size_mask(st_funct3)} << st_off;
        st_data = {32'b0, st_trunc} << {st_off, 3'b000};
    end

    // The addressed bytes always sit inside a 32-bit window starting at
    // byte 'off' of the two-word assembly.
    always_comb begin
        ld_window = ld_data[{ld_off, 3'b000} +: 32];
        ld_result = ld_window;
        case (ld_funct3)
            F3_LB:   ld_result = {{24{ld_window[7]}},  ld_window[7:0]};
            F3_LH:   ld_result = {{16{ld_window[15]}}, ld_window[15:0]};
            F3_LBU:  ld_result = {24'b0, ld_window[7:0]};
            F3_LHU:  ld_result = {16'b0, ld_window[15:0]};
            default: ld_result = ld_window;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Load/store initiator between the MEM stage and a single-port data RAM.
// Issues one or two aligned RAM accesses per request (two when the access
// crosses a word boundary), realigns/extends load data and stalls the
// pipeline until the response cycle.
// Ports:
//   clk, rst (synchronous, active low)
//   req_valid, req_we, req_funct3, req_addr, req_wdata   : request from MEM
//   resp_valid, resp_rdata, resp_err, stall_req          : response/stall
//   ram_ce, ram_we, ram_addr, ram_sel, ram_wdata         : RAM command
//   ram_rdata                                            : RAM read data
// ---------------------------------------------------------------------------
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic          stall_req,
    output logic          ram_ce,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [3:0]    ram_sel,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    state_t        state;
    logic [1:0]    off_q;
    logic [AW-1:0] base_q;
    logic          we_q;
    logic [2:0]    funct3_q;
    logic [7:0]    mask_q;
    logic [63:0]   wdata_q;
    logic [31:0]   lo_q;

    logic [7:0]    st_mask;
    logic [63:0]   st_data;
    logic [63:0]   ld_data;
    logic [31:0]   ld_result;
    logic [AW-1:0] req_base;

    assign req_base = {req_addr[AW-1:2], 2'b00};

    // The response is registered at the edge that ends the last RAM cycle,
    // so the word being read in that cycle is taken straight from the RAM
    // instead of from a capture register. A single-access load never uses
    // the upper half of the assembly, so it is simply zero there.
    always_comb begin
        ld_data = {32'b0, lo_q};
        if (state == ST_ACC0)
            ld_data = {32'b0, ram_rdata};
        else if (state == ST_ACC1)
            ld_data = {ram_rdata, lo_q};
    end

    lsu_align u_align (
        .st_funct3 (req_funct3),
        .st_off    (req_addr[1:0]),
        .st_wdata  (req_wdata),
        .st_mask   (st_mask),
        .st_data   (st_data),
        .ld_funct3 (funct3_q),
        .ld_off    (off_q),
        .ld_data   (ld_data),
        .ld_result (ld_result)
    );

    // Stall is combinational on req_valid so the MEM stage holds in the
    // very cycle the request is accepted; it drops in DONE so the pipeline
    // advances together with the response.
    assign stall_req = ((state == ST_IDLE) && req_valid) ||
                       (state == ST_ACC0) || (state == ST_ACC1);

    // Main FSM. All RAM and response outputs are registered and are loaded
    // one edge ahead of the state in which they must be visible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            off_q      <= '0;
            base_q     <= '0;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            mask_q     <= '0;
            wdata_q    <= '0;
            lo_q       <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            ram_ce     <= RAM_DIS;
            ram_we     <= RAM_DIS;
            ram_addr   <= '0;
            ram_sel    <= '0;
            ram_wdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    ram_ce     <= RAM_DIS;
                    ram_we     <= RAM_DIS;
                    ram_addr   <= '0;
                    ram_sel    <= '0;
                    ram_wdata  <= '0;
                    if (req_valid) begin
                        off_q    <= req_addr[1:0];
                        base_q   <= req_base;
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        mask_q   <= st_mask;
                        wdata_q  <= st_data;
                        if (f3_illegal(req_we, req_funct3)) begin
                            state      <= ST_DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state     <= ST_ACC0;
                            ram_ce    <= RAM_EN;
                            ram_we    <= req_we ? RAM_EN : RAM_DIS;
                            ram_addr  <= req_base;
                            ram_sel   <= st_mask[3:0];
                            ram_wdata <= st_data[31:0];
                        end
                    end
                end

                ST_ACC0: begin
                    if (!we_q)
                        lo_q <= ram_rdata;
                    if (mask_q[7:4] != 4'b0000) begin
                        state     <= ST_ACC1;
                        ram_addr  <= base_q + AW'(4);
                        ram_sel   <= mask_q[7:4];
                        ram_wdata <= wdata_q[63:32];
                    end else begin
                        state      <= ST_DONE;
                        ram_ce     <= RAM_DIS;
                        ram_we     <= RAM_DIS;
                        ram_addr   <= '0;
                        ram_sel    <= '0;
                        ram_wdata  <= '0;
                        resp_valid <= 1'b1;
                        resp_rdata <= we_q ? '0 : ld_result;
                    end
                end

                ST_ACC1: begin
                    state      <= ST_DONE;
                    ram_ce     <= RAM_DIS;
                    ram_we     <= RAM_DIS;
                    ram_addr   <= '0;
                    ram_sel    <= '0;
                    ram_wdata  <= '0;
                    resp_valid <= 1'b1;
                    resp_rdata <= we_q ? '0 : ld_result;
                end

                default: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed bench for mem_access_ctrl. A byte-wide behavioural RAM answers the
// DUT combinationally and commits writes on the rising edge. Each request is
// driven at a falling edge; the outputs are then recorded every falling edge
// until the response shows up, and the recorded trace is compared against
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall_req;
    logic        ram_ce;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [3:0]  ram_sel;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    always #5 clk = ~clk;

    mem_access_ctrl #(.AW(32), .DW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .stall_req  (stall_req),
        .ram_ce     (ram_ce),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_sel    (ram_sel),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // 1 KiB behavioural RAM; only the low address bits are decoded, so
    // addresses near 0xFFFFFFFF alias to the top of the array.
    logic [7:0] mem [0:1023];

    assign ram_rdata = {mem[{ram_addr[9:2], 2'd3}], mem[{ram_addr[9:2], 2'd2}],
                        mem[{ram_addr[9:2], 2'd1}], mem[{ram_addr[9:2], 2'd0}]};

    always @(posedge clk) begin
        if (ram_ce && ram_we) begin
            for (int k = 0; k < 4; k++)
                if (ram_sel[k])
                    mem[{ram_addr[9:2], 2'(k)}] <= ram_wdata[8*k +: 8];
        end
    end

    int vectors     = 0;
    int miscompares = 0;

    // Per-cycle trace of one transaction, index 1 = cycle T+1
    logic        rec_ce    [1:6];
    logic        rec_we    [1:6];
    logic [31:0] rec_addr  [1:6];
    logic [3:0]  rec_sel   [1:6];
    logic [31:0] rec_wdata [1:6];
    logic        rec_stall [1:6];
    int          resp_n;
    logic [31:0] resp_data;
    logic        resp_e;
    logic        stall_t0;

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drives one request at a falling edge, keeps garbage on the request
    // inputs while the access is in flight, and records the outputs until
    // the response appears (bounded to six cycles).
    task automatic applyStimulus(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        #1 stall_t0 = stall_req;
        resp_n    = 0;
        resp_data = '0;
        resp_e    = 1'b0;
        for (int n = 1; n <= 6 && resp_n == 0; n++) begin
            @(negedge clk);
            rec_ce[n]    = ram_ce;
            rec_we[n]    = ram_we;
            rec_addr[n]  = ram_addr;
            rec_sel[n]   = ram_sel;
            rec_wdata[n] = ram_wdata;
            rec_stall[n] = stall_req;
            if (resp_valid) begin
                resp_n    = n;
                resp_data = resp_rdata;
                resp_e    = resp_err;
                req_valid = 1'b0;
            end else begin
                req_valid  = 1'b1;
                req_we     = ~we;
                req_funct3 = 3'd7;
                req_addr   = 32'hFFFF_FFF0;
                req_wdata  = 32'h5A5A_5A5A;
            end
        end
        req_valid = 1'b0;
        checkOutput("resp_seen", 32'(resp_n != 0), 32'd1);
        @(negedge clk);
        checkOutput("resp_one_cycle", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        checkOutput("rst_ctrl", 32'({ram_ce, ram_we, ram_sel, resp_valid, resp_err, stall_req}), 32'd0);
        checkOutput("rst_addr", ram_addr, 32'd0);
        checkOutput("rst_wdata", ram_wdata, 32'd0);
        checkOutput("rst_rdata", resp_rdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // SW 0xDEADBEEF @0x100
        applyStimulus(1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF);
        checkOutput("sw_latency", 32'(resp_n), 32'd2);
        checkOutput("sw_ce_we", 32'({rec_ce[1], rec_we[1]}), 32'b11);
        checkOutput("sw_addr", rec_addr[1], 32'h100);
        checkOutput("sw_sel", 32'(rec_sel[1]), 32'hF);
        checkOutput("sw_wdata", rec_wdata[1], 32'hDEAD_BEEF);
        checkOutput("sw_rdata", resp_data, 32'd0);
        checkOutput("sw_done_ce", 32'({rec_ce[2], rec_we[2], rec_sel[2]}), 32'd0);

        // LW @0x100
        applyStimulus(1'b0, 3'd2, 32'h100, 32'h0);
        checkOutput("lw_latency", 32'(resp_n), 32'd2);
        checkOutput("lw_rdata", resp_data, 32'hDEAD_BEEF);
        checkOutput("lw_err", 32'(resp_e), 32'd0);
        checkOutput("lw_stall", 32'({stall_t0, rec_stall[1], rec_stall[2]}), 32'b110);
        checkOutput("lw_ram_we", 32'({rec_ce[1], rec_we[1]}), 32'b10);

        // SB 0x80 @0x103; upper store-data bits must be discarded
        applyStimulus(1'b1, 3'd0, 32'h103, 32'hAAAA_AA80);
        checkOutput("sb_sel", 32'(rec_sel[1]), 32'b1000);
        checkOutput("sb_wdata", rec_wdata[1], 32'h8000_0000);
        applyStimulus(1'b0, 3'd0, 32'h103, 32'h0);
        checkOutput("lb_rdata", resp_data, 32'hFFFF_FF80);
        applyStimulus(1'b0, 3'd4, 32'h103, 32'h0);
        checkOutput("lbu_rdata", resp_data, 32'h0000_0080);
        applyStimulus(1'b0, 3'd2, 32'h100, 32'h0);
        checkOutput("sb_neighbours", resp_data, 32'h80AD_BEEF);
        applyStimulus(1'b0, 3'd5, 32'h100, 32'h0);
        checkOutput("lhu_aligned", resp_data, 32'h0000_BEEF);

        // Crossing SW 0x11223344 @0x202
        applyStimulus(1'b1, 3'd2, 32'h202, 32'h1122_3344);
        checkOutput("xsw_latency", 32'(resp_n), 32'd3);
        checkOutput("xsw_addr0", rec_addr[1], 32'h200);
        checkOutput("xsw_sel0", 32'(rec_sel[1]), 32'b1100);
        checkOutput("xsw_wdata0", rec_wdata[1], 32'h3344_0000);
        checkOutput("xsw_addr1", rec_addr[2], 32'h204);
        checkOutput("xsw_sel1", 32'(rec_sel[2]), 32'b0011);
        checkOutput("xsw_wdata1", rec_wdata[2], 32'h0000_1122);
        checkOutput("xsw_we1", 32'({rec_ce[2], rec_we[2]}), 32'b11);
        applyStimulus(1'b0, 3'd2, 32'h202, 32'h0);
        checkOutput("xlw_latency", 32'(resp_n), 32'd3);
        checkOutput("xlw_rdata", resp_data, 32'h1122_3344);

        // Crossing halfword: bytes 0x207=0x34, 0x208=0x92
        applyStimulus(1'b1, 3'd0, 32'h207, 32'h0000_0034);
        applyStimulus(1'b1, 3'd0, 32'h208, 32'h0000_0092);
        applyStimulus(1'b0, 3'd1, 32'h207, 32'h0);
        checkOutput("xlh_latency", 32'(resp_n), 32'd3);
        checkOutput("xlh_sel", 32'({rec_sel[1], rec_sel[2]}), 32'b1000_0001);
        checkOutput("xlh_rdata", resp_data, 32'hFFFF_9234);
        applyStimulus(1'b0, 3'd5, 32'h207, 32'h0);
        checkOutput("xlhu_rdata", resp_data, 32'h0000_9234);

        // Illegal funct3 on a load and on a store
        applyStimulus(1'b0, 3'd3, 32'h100, 32'h0);
        checkOutput("ill_ld_latency", 32'(resp_n), 32'd1);
        checkOutput("ill_ld_ce", 32'(rec_ce[1]), 32'd0);
        checkOutput("ill_ld_err", 32'(resp_e), 32'd1);
        checkOutput("ill_ld_rdata", resp_data, 32'd0);
        checkOutput("ill_ld_stall", 32'({stall_t0, rec_stall[1]}), 32'b10);
        applyStimulus(1'b1, 3'd3, 32'h100, 32'hFFFF_FFFF);
        checkOutput("ill_st_ce", 32'({rec_ce[1], rec_we[1]}), 32'd0);
        checkOutput("ill_st_err", 32'(resp_e), 32'd1);
        applyStimulus(1'b0, 3'd2, 32'h100, 32'h0);
        checkOutput("ill_st_nowrite", resp_data, 32'h80AD_BEEF);

        // Reset during ACC0 of a crossing SW
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'h302;
        req_wdata  = 32'hAABB_CCDD;
        @(negedge clk);
        checkOutput("rst_acc0_addr", ram_addr, 32'h300);
        req_valid = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_ctrl", 32'({ram_ce, ram_we, ram_sel, resp_valid, resp_err, stall_req}), 32'd0);
        checkOutput("rst_mid_addr", ram_addr, 32'd0);
        checkOutput("rst_mid_wdata", ram_wdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_no_resp", 32'(resp_valid), 32'd0);
        applyStimulus(1'b0, 3'd2, 32'h302, 32'h0);
        checkOutput("rst_half_written", resp_data, 32'h0000_CCDD);

        // Upper-word address wraps past the top of the address space
        applyStimulus(1'b0, 3'd5, 32'hFFFF_FFFF, 32'h0);
        checkOutput("wrap_addr0", rec_addr[1], 32'hFFFF_FFFC);
        checkOutput("wrap_addr1", rec_addr[2], 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
